// File: rtl/cnn_mac_seq_if.sv
// Handshake, data and external-multiplier signals of the sequential CNN MAC.
// The slave view belongs to the MAC; the master view drives it.
interface cnn_mac_seq_if;
  logic               ap_start;
  logic               ap_done;
  logic               ap_idle;
  logic               ap_ready;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  w_in;
  logic signed [13:0] x_in;
  logic signed [7:0]  mul_din0;
  logic signed [13:0] mul_din1;
  logic signed [21:0] mul_dout;
  logic signed [13:0] res;
  logic               res_ovf;

  modport slave (
    input  ap_start, in_valid, w_in, x_in, mul_dout,
    output ap_done, ap_idle, ap_ready, in_ready, mul_din0, mul_din1, res, res_ovf
  );

  modport master (
    output ap_start, in_valid, w_in, x_in, mul_dout,
    input  ap_done, ap_idle, ap_ready, in_ready, mul_din0, mul_din1, res, res_ovf
  );
endinterface

// File: rtl/cnn_mac_seq.sv
// Sequential dot-product MAC: LEN weight/activation pairs through an external
// multiplier, accumulated at full precision, floor-shifted and saturated to 14 bits.
module cnn_mac_seq #(
  parameter int LEN   = 25,
  parameter int SHIFT = 7
) (
  input  logic         ap_clk,
  input  logic         ap_rst,
  cnn_mac_seq_if.slave bus
);

  localparam int COEF_W = 8;
  localparam int DATA_W = 14;
  localparam int PROD_W = COEF_W + DATA_W;
  localparam int ACC_W  = PROD_W + $clog2(LEN);
  localparam int CNT_W  = $clog2(LEN + 1);

  localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'(8191);
  localparam logic signed [ACC_W-1:0] RES_MIN = -ACC_W'(8192);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         count;
  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1;
  logic signed [ACC_W-1:0]  acc_p2;
  logic signed [DATA_W-1:0] res_p3;
  logic                     ovf_p3;

  logic                     accept;
  logic                     last;
  logic signed [ACC_W-1:0]  acc_final;
  logic [DATA_W:0]          sat_res;

  // Returns {clamped, value}; >>> on a signed operand floors toward -inf.
  function automatic logic [DATA_W:0] sat14(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] sh;
    sh = v >>> SHIFT;
    if (sh > RES_MAX)      sat14 = {1'b1, DATA_W'(8191)};
    else if (sh < RES_MIN) sat14 = {1'b1, DATA_W'(-8192)};
    else                   sat14 = {1'b0, sh[DATA_W-1:0]};
  endfunction

  assign accept    = (state == RUN) && bus.in_valid;
  assign last      = accept && (count == CNT_W'(LEN - 1));
  assign acc_final = acc_p2 + ACC_W'(prod_p1);
  assign sat_res   = sat14(acc_final);

  assign bus.mul_din0 = bus.w_in;
  assign bus.mul_din1 = bus.x_in;
  assign bus.in_ready = (state == RUN);
  assign bus.ap_idle  = (state == IDLE);
  assign bus.ap_done  = (state == DONE);
  assign bus.ap_ready = last;
  assign bus.res      = res_p3;
  assign bus.res_ovf  = ovf_p3;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state   <= IDLE;
      count   <= '0;
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      acc_p2  <= '0;
      res_p3  <= '0;
      ovf_p3  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ap_start) begin
            state  <= RUN;
            acc_p2 <= '0;
            count  <= '0;
            vld_p1 <= 1'b0;
          end
        end
        RUN: begin
          // Stage p1 -> p2: fold the previous product while capturing the next.
          if (vld_p1) acc_p2 <= acc_final;
          if (accept) begin
            prod_p1 <= bus.mul_dout;
            vld_p1  <= 1'b1;
            count   <= count + CNT_W'(1);
          end else begin
            vld_p1  <= 1'b0;
          end
          if (last) state <= DRAIN;
        end
        DRAIN: begin
          // Stage p2 -> p3: the final product is always pending here.
          acc_p2 <= acc_final;
          res_p3 <= sat_res[DATA_W-1:0];
          ovf_p3 <= sat_res[DATA_W];
          vld_p1 <= 1'b0;
          state  <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_mac_seq.sv
// Directed bench for cnn_mac_seq: LEN=25 instance for the main scenarios,
// LEN=1 instance for the single-pair corner.
module tb_cnn_mac_seq;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_tot;

  logic signed [7:0]  wv [25];
  logic signed [13:0] xv [25];

  cnn_mac_seq_if b ();
  cnn_mac_seq_if b1 ();

  cnn_mac_seq #(.LEN(25), .SHIFT(7)) dut (.ap_clk(clk), .ap_rst(rst), .bus(b.slave));
  cnn_mac_seq #(.LEN(1),  .SHIFT(7)) dut1 (.ap_clk(clk), .ap_rst(rst), .bus(b1.slave));

  // Behavioural external multiplier, 22-bit signed product.
  assign b.mul_dout  = $signed({{14{b.mul_din0[7]}}, b.mul_din0}) *
                       $signed({{8{b.mul_din1[13]}}, b.mul_din1});
  assign b1.mul_dout = $signed({{14{b1.mul_din0[7]}}, b1.mul_din0}) *
                       $signed({{8{b1.mul_din1[13]}}, b1.mul_din1});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_data(input logic signed [7:0] w, input logic signed [13:0] x,
                          input logic signed [7:0] wf, input logic signed [13:0] xf);
    for (int i = 0; i < 25; i++) begin
      wv[i] = w;
      xv[i] = x;
    end
    wv[0] = wf;
    xv[0] = xf;
  endtask

  // Cycle 0 is the cycle ap_start is high; inputs change 1 ns after each rising edge.
  task automatic run_op(input bit odd, input bit poke, input int abort_after,
                        output int rdy_cyc, output int done_cyc, output int last_acc,
                        output int nacc);
    int idx;
    idx      = 0;
    rdy_cyc  = -1;
    done_cyc = -1;
    last_acc = -1;
    @(posedge clk); #1;
    b.ap_start = 1'b1;
    b.in_valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (b.in_valid && b.in_ready) begin
        idx++;
        last_acc = c;
      end
      if (b.ap_ready) rdy_cyc = c;
      if (b.ap_done) begin
        done_cyc = c;
        break;
      end
      if (abort_after > 0 && idx == abort_after) break;
      @(posedge clk); #1;
      b.ap_start = poke && ((c + 1) == 5 || (c + 1) == 27);
      b.in_valid = (idx < 25) && (!odd || ((c + 1) % 2 == 1));
      b.w_in     = wv[idx % 25];
      b.x_in     = xv[idx % 25];
    end
    nacc = idx;
    @(posedge clk); #1;
    b.ap_start = 1'b0;
    b.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    b.ap_start = 1'b0; b.in_valid = 1'b0; b.w_in = '0; b.x_in = '0;
    b1.ap_start = 1'b0; b1.in_valid = 1'b0; b1.w_in = '0; b1.x_in = '0;
    repeat (2) @(negedge clk);
    n_tot++; if (b.ap_idle !== 1'b1) $display("FAIL rst_idle got %b want 1", b.ap_idle); else n_pass++;
    n_tot++; if (b.ap_done !== 1'b0 || b.ap_ready !== 1'b0 || b.in_ready !== 1'b0)
      $display("FAIL rst_ctl got done=%b ready=%b in_ready=%b want 0 0 0", b.ap_done, b.ap_ready, b.in_ready);
    else n_pass++;
    n_tot++; if (b.res !== 14'h0000 || b.res_ovf !== 1'b0)
      $display("FAIL rst_res got %h/%b want 0000/0", b.res, b.res_ovf); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int r, d, l, n;
    set_data(8'sd1, 14'sd128, 8'sd1, 14'sd128);
    run_op(1'b0, 1'b0, 0, r, d, l, n);
    n_tot++; if (b.res !== 14'd25 || b.res_ovf !== 1'b0)
      $display("FAIL basic_res got %0d/%b want 25/0", $signed(b.res), b.res_ovf); else n_pass++;
    n_tot++; if (r !== 25) $display("FAIL basic_ready_cycle got %0d want 25", r); else n_pass++;
    n_tot++; if (d !== 27) $display("FAIL basic_done_cycle got %0d want 27", d); else n_pass++;
    n_tot++; if (n !== 25) $display("FAIL basic_accepts got %0d want 25", n); else n_pass++;
  endtask

  task automatic test_saturation;
    int r, d, l, n;
    set_data(8'sd127, 14'sd8191, 8'sd127, 14'sd8191);
    run_op(1'b0, 1'b0, 0, r, d, l, n);
    n_tot++; if (b.res !== 14'h1FFF || b.res_ovf !== 1'b1)
      $display("FAIL sat_pos got %h/%b want 1fff/1", b.res, b.res_ovf); else n_pass++;
    set_data(-8'sd128, 14'sd8191, -8'sd128, 14'sd8191);
    run_op(1'b0, 1'b0, 0, r, d, l, n);
    n_tot++; if (b.res !== 14'h2000 || b.res_ovf !== 1'b1)
      $display("FAIL sat_neg got %h/%b want 2000/1", b.res, b.res_ovf); else n_pass++;
  endtask

  task automatic test_floor;
    int r, d, l, n;
    set_data(8'sd0, 14'sd0, -8'sd1, 14'sd1);
    run_op(1'b0, 1'b0, 0, r, d, l, n);
    n_tot++; if (b.res !== 14'h3FFF || b.res_ovf !== 1'b0)
      $display("FAIL floor_shift got %h/%b want 3fff/0", b.res, b.res_ovf); else n_pass++;
  endtask

  task automatic test_stall;
    int r, d, l, n;
    set_data(8'sd1, 14'sd128, 8'sd1, 14'sd128);
    run_op(1'b1, 1'b0, 0, r, d, l, n);
    n_tot++; if (b.res !== 14'd25 || b.res_ovf !== 1'b0)
      $display("FAIL stall_res got %0d/%b want 25/0", $signed(b.res), b.res_ovf); else n_pass++;
    n_tot++; if (l !== 49) $display("FAIL stall_last_accept got %0d want 49", l); else n_pass++;
    n_tot++; if (d !== 51) $display("FAIL stall_done_cycle got %0d want 51", d); else n_pass++;
  endtask

  task automatic test_abort;
    int r, d, l, n;
    bit saw_done;
    set_data(8'sd1, 14'sd128, 8'sd1, 14'sd128);
    run_op(1'b0, 1'b0, 10, r, d, l, n);
    rst = 1'b1;
    #1;
    n_tot++; if (b.ap_idle !== 1'b1 || b.in_ready !== 1'b0 || b.ap_ready !== 1'b0)
      $display("FAIL abort_ctl got idle=%b in_ready=%b ready=%b want 1 0 0", b.ap_idle, b.in_ready, b.ap_ready);
    else n_pass++;
    n_tot++; if (b.res !== 14'h0000) $display("FAIL abort_res_clear got %h want 0000", b.res); else n_pass++;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (b.ap_done) saw_done = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (b.ap_done) saw_done = 1'b1;
    end
    n_tot++; if (saw_done !== 1'b0) $display("FAIL abort_no_done got %b want 0", saw_done); else n_pass++;
    n_tot++; if (b.ap_idle !== 1'b1) $display("FAIL abort_idle got %b want 1", b.ap_idle); else n_pass++;
    run_op(1'b0, 1'b0, 0, r, d, l, n);
    n_tot++; if (b.res !== 14'd25 || d !== 27)
      $display("FAIL abort_fresh got res=%0d done=%0d want 25 27", $signed(b.res), d); else n_pass++;
  endtask

  task automatic test_start_ignored;
    int r, d, l, n;
    set_data(8'sd1, 14'sd0, 8'sd1, 14'sd0);
    run_op(1'b0, 1'b0, 0, r, d, l, n);
    set_data(8'sd1, 14'sd128, 8'sd1, 14'sd128);
    run_op(1'b0, 1'b1, 0, r, d, l, n);
    n_tot++; if (b.res !== 14'd25 || d !== 27)
      $display("FAIL poke_run got res=%0d done=%0d want 25 27", $signed(b.res), d); else n_pass++;
    @(negedge clk);
    n_tot++; if (b.ap_idle !== 1'b1) $display("FAIL poke_idle_after got %b want 1", b.ap_idle); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_tot++; if (b.ap_idle !== 1'b1 || b.in_ready !== 1'b0)
      $display("FAIL poke_no_restart got idle=%b in_ready=%b want 1 0", b.ap_idle, b.in_ready); else n_pass++;
    n_tot++; if (b.res !== 14'd25) $display("FAIL res_hold got %0d want 25", $signed(b.res)); else n_pass++;
  endtask

  task automatic test_len1;
    @(posedge clk); #1;
    b1.ap_start = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    b1.ap_start = 1'b0;
    b1.in_valid = 1'b1;
    b1.w_in     = 8'sd2;
    b1.x_in     = 14'sd64;
    @(negedge clk);
    n_tot++; if (b1.in_ready !== 1'b1 || b1.ap_ready !== 1'b1)
      $display("FAIL len1_accept got in_ready=%b ready=%b want 1 1", b1.in_ready, b1.ap_ready); else n_pass++;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    @(negedge clk);
    n_tot++; if (b1.ap_done !== 1'b0) $display("FAIL len1_done_early got %b want 0", b1.ap_done); else n_pass++;
    @(negedge clk);
    n_tot++; if (b1.ap_done !== 1'b1) $display("FAIL len1_done_cycle3 got %b want 1", b1.ap_done); else n_pass++;
    n_tot++; if (b1.res !== 14'd1 || b1.res_ovf !== 1'b0)
      $display("FAIL len1_res got %0d/%b want 1/0", $signed(b1.res), b1.res_ovf); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_floor();
    test_stall();
    test_abort();
    test_start_ignored();
    test_len1();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
